// File: rtl/decoder_pkg.sv
// decoder_pkg: shared types and constants for decoder_pipe.
//   dec_mode_e  : per-transaction decode mode (one-hot / thermometer)
//   dec_state_e : occupancy state of the output/skid storage
//   STAT_W      : width of the optional transfer counters
//   cmp_width() : width used to compare a code against OUT_W without wrap
package decoder_pkg;

  typedef enum logic {
    DEC_ONEHOT = 1'b0,
    DEC_THERMO = 1'b1
  } dec_mode_e;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_TWO
  } dec_state_e;

  localparam int unsigned STAT_W = 16;

  // Wide enough to hold both any input code and the value OUT_W itself.
  function automatic int unsigned cmp_width(int unsigned in_w, int unsigned out_w);
    int unsigned lim_w;
    lim_w = $clog2(out_w) + 1;
    return (in_w > lim_w) ? in_w : lim_w;
  endfunction

endpackage

// File: rtl/decoder_core.sv
// decoder_core: combinational binary decoder.
//   i_code [IN_W]  : binary code
//   i_mode         : DEC_ONEHOT -> vec[i] = (i == code)
//                    DEC_THERMO -> vec[i] = (i <= code)
//   o_vec  [OUT_W] : decoded vector, all zero when the code is out of range
//   o_err          : code >= OUT_W
module decoder_core
  import decoder_pkg::*;
#(
  parameter int unsigned IN_W  = 2,
  parameter int unsigned OUT_W = 4
) (
  input  logic [IN_W-1:0]  i_code,
  input  dec_mode_e        i_mode,
  output logic [OUT_W-1:0] o_vec,
  output logic             o_err
);

  localparam int unsigned CMP_W = cmp_width(IN_W, OUT_W);

  logic [CMP_W-1:0] w_code_x;
  logic [CMP_W-1:0] w_lim;

  // Zero-extend so a code equal to OUT_W never aliases back onto line 0.
  assign w_code_x = CMP_W'(i_code);
  assign w_lim    = CMP_W'(OUT_W);

  always_comb begin
    o_err = (w_code_x >= w_lim);
    o_vec = '0;
    if (!o_err) begin
      for (int unsigned i = 0; i < OUT_W; i++) begin
        if (i_mode == DEC_THERMO) o_vec[i] = (CMP_W'(i) <= w_code_x);
        else                      o_vec[i] = (CMP_W'(i) == w_code_x);
      end
    end
  end

endmodule

// File: rtl/decoder_pipe.sv
// decoder_pipe: registered N-to-M decoder with valid/ready on both sides and
// a two-entry (output register + skid register) buffer.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : input handshake; in_ready depends on state only
//   in_code, in_mode      : code to decode, 0 = one-hot, 1 = thermometer
//   out_valid/out_ready   : output handshake
//   out_vec, out_err      : decoded vector and out-of-range flag
// Optional (macro DECODER_PIPE_STATS_EN):
//   stat_cnt, stat_err_cnt: saturating counts of output transfers / error transfers
module decoder_pipe
  import decoder_pkg::*;
#(
  parameter int unsigned IN_W       = 2,
  parameter int unsigned OUT_W      = 4,
  parameter int unsigned THERMO_DEF = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_code,
  input  logic              in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_vec,
  output logic              out_err
`ifdef DECODER_PIPE_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_cnt,
  output logic [STAT_W-1:0] stat_err_cnt
`endif
);

  // THERMO_DEF only documents the integration default of in_mode.
  generate
    if (IN_W < 1 || IN_W > 8 || OUT_W < 1 || OUT_W > (1 << IN_W) || THERMO_DEF > 1) begin : g_bad_param
      $error("decoder_pipe: illegal parameter set");
    end
  endgenerate

  dec_state_e       r_state;
  dec_state_e       w_state_nxt;
  logic [OUT_W-1:0] r_or_vec;
  logic             r_or_err;
  logic [OUT_W-1:0] r_sk_vec;
  logic             r_sk_err;

  logic [OUT_W-1:0] w_dec_vec;
  logic             w_dec_err;
  logic             w_accept;
  logic             w_xfer;
  logic             w_load_or_new;
  logic             w_load_or_sk;
  logic             w_load_sk;

  decoder_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .i_code (in_code),
    .i_mode (dec_mode_e'(in_mode)),
    .o_vec  (w_dec_vec),
    .o_err  (w_dec_err)
  );

  assign w_accept = in_valid && in_ready;
  assign w_xfer   = out_valid && out_ready;
  assign out_vec  = r_or_vec;
  assign out_err  = r_or_err;

  always_comb begin
    w_state_nxt   = r_state;
    w_load_or_new = 1'b0;
    w_load_or_sk  = 1'b0;
    w_load_sk     = 1'b0;
    out_valid     = (r_state != ST_EMPTY);
    in_ready      = (r_state != ST_TWO) && !rst;
    unique case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_state_nxt   = ST_ONE;
          w_load_or_new = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_accept && w_xfer) begin
          w_load_or_new = 1'b1;
        end else if (w_accept) begin
          w_state_nxt = ST_TWO;
          w_load_sk   = 1'b1;
        end else if (w_xfer) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (w_xfer) begin
          w_state_nxt  = ST_ONE;
          w_load_or_sk = 1'b1;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_EMPTY;
      r_or_vec <= '0;
      r_or_err <= 1'b0;
      r_sk_vec <= '0;
      r_sk_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load_or_new) begin
        r_or_vec <= w_dec_vec;
        r_or_err <= w_dec_err;
      end else if (w_load_or_sk) begin
        r_or_vec <= r_sk_vec;
        r_or_err <= r_sk_err;
      end
      if (w_load_sk) begin
        r_sk_vec <= w_dec_vec;
        r_sk_err <= w_dec_err;
      end
    end
  end

`ifdef DECODER_PIPE_STATS_EN
  logic [STAT_W-1:0] r_stat_cnt;
  logic [STAT_W-1:0] r_stat_err_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_cnt     <= '0;
      r_stat_err_cnt <= '0;
    end else if (w_xfer) begin
      if (r_stat_cnt != '1)                  r_stat_cnt     <= r_stat_cnt + STAT_W'(1);
      if (r_or_err && (r_stat_err_cnt != '1)) r_stat_err_cnt <= r_stat_err_cnt + STAT_W'(1);
    end
  end

  assign stat_cnt     = r_stat_cnt;
  assign stat_err_cnt = r_stat_err_cnt;
`endif

endmodule

// File: tb/tb_decoder_pipe.sv
// tb_decoder_pipe: self-checking bench for decoder_pipe (IN_W=3, OUT_W=6).
// A queue-based reference model predicts every output transfer; directed
// sequences pin literal values for decode, backpressure and reset.
module tb_decoder_pipe;
  import decoder_pkg::*;

  localparam int unsigned IN_W  = 3;
  localparam int unsigned OUT_W = 6;

  typedef struct packed {
    logic             err;
    logic [OUT_W-1:0] vec;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [IN_W-1:0]   in_code;
  logic              in_mode;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_vec;
  logic              out_err;
`ifdef DECODER_PIPE_STATS_EN
  logic [STAT_W-1:0] stat_cnt;
  logic [STAT_W-1:0] stat_err_cnt;
  int unsigned       m_stat_cnt;
  int unsigned       m_stat_err;
`endif

  int   checks = 0;
  int   passes = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  decoder_pipe #(
    .IN_W       (IN_W),
    .OUT_W      (OUT_W),
    .THERMO_DEF (0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_code   (in_code),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vec   (out_vec),
    .out_err   (out_err)
`ifdef DECODER_PIPE_STATS_EN
    ,
    .stat_cnt     (stat_cnt),
    .stat_err_cnt (stat_err_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference decode straight from the rules: one-hot = single bit at code,
  // thermometer = all bits up to and including code, out of range = error.
  function automatic exp_t ref_dec(input int unsigned code, input bit mode);
    exp_t e;
    e.err = (code >= OUT_W);
    e.vec = '0;
    if (!e.err) e.vec = mode ? OUT_W'((1 << (code + 1)) - 1) : OUT_W'(1 << code);
    return e;
  endfunction

  // Monitor on the falling edge: inputs/outputs here are what the next
  // rising edge will see.
  logic             prev_stall = 1'b0;
  logic [OUT_W-1:0] prev_vec;
  logic             prev_err;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      prev_stall = 1'b0;
`ifdef DECODER_PIPE_STATS_EN
      m_stat_cnt = 0;
      m_stat_err = 0;
`endif
    end else begin
      if (prev_stall)
        check("stall_stable", {out_valid, out_err, out_vec}, {1'b1, prev_err, prev_vec});
      if (out_valid && out_ready) begin
        check("xfer_expected", q.size() != 0, 1);
        if (q.size() != 0) begin
          exp_t e;
          e = q.pop_front();
          check("xfer_data", {out_err, out_vec}, {e.err, e.vec});
        end
`ifdef DECODER_PIPE_STATS_EN
        if (m_stat_cnt < 65535) m_stat_cnt++;
        if (out_err && m_stat_err < 65535) m_stat_err++;
`endif
      end
      if (in_valid && in_ready) q.push_back(ref_dec(in_code, in_mode));
      prev_stall = out_valid && !out_ready;
      prev_vec   = out_vec;
      prev_err   = out_err;
    end
  end

  task automatic send_chk(input int unsigned code, input bit mode,
                          input logic [OUT_W-1:0] evec, input logic eerr);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_code  = IN_W'(code);
    in_mode  = mode;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("lat_valid", out_valid, 1);
    check($sformatf("dec_c%0d_m%0d", code, mode), {out_err, out_vec}, {eerr, evec});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [OUT_W-1:0] oh_tab [8];
    int unsigned acc;
    int unsigned cyc;
    bit          last_acc;

    oh_tab = '{6'b000001, 6'b000010, 6'b000100, 6'b001000,
               6'b010000, 6'b100000, 6'b000000, 6'b000000};

    rst = 1'b1; in_valid = 1'b0; in_code = '0; in_mode = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_vec",   out_vec,   0);
    check("rst_out_err",   out_err,   0);
    check("rst_in_ready",  in_ready,  0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // One-hot sweep including the out-of-range codes.
    for (int unsigned c = 0; c < 8; c++)
      send_chk(c, 1'b0, oh_tab[c], (c >= 6) ? 1'b1 : 1'b0);

    // Thermometer.
    send_chk(3, 1'b1, 6'b001111, 1'b0);
    send_chk(0, 1'b1, 6'b000001, 1'b0);
    send_chk(5, 1'b1, 6'b111111, 1'b0);
    send_chk(6, 1'b1, 6'b000000, 1'b1);
    send_chk(7, 1'b1, 6'b000000, 1'b1);
    repeat (2) @(posedge clk);

    // Backpressure: codes 1,2,3 with the consumer stalled.
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_code = 3'd1; in_mode = 1'b0;
    @(posedge clk); #1;
    check("bp_ready_after1", in_ready, 1);
    in_code = 3'd2;
    @(posedge clk); #1;
    check("bp_ready_after2", in_ready, 0);
    check("bp_head", out_vec, 6'b000010);
    in_code = 3'd3;
    repeat (3) begin
      @(posedge clk); #1;
      check("bp_hold_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_second", out_vec, 6'b000100);
    check("bp_ready_back", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_third", {out_valid, out_vec}, {1'b1, 6'b001000});
    @(posedge clk); #1;
    check("bp_drained", out_valid, 0);

    // Reset with two entries stored.
    out_ready = 1'b0; in_valid = 1'b1; in_code = 3'd4; in_mode = 1'b0;
    @(posedge clk); #1;
    in_code = 3'd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("pre_rst_full", in_ready, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_vec",   out_vec,   0);
    check("mid_rst_in_ready",  in_ready,  0);
    rst = 1'b0;
    #1;
    check("mid_rst_release_ready", in_ready, 1);
    out_ready = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      check("no_stale_entry", out_valid, 0);
    end

    // Random valid/ready traffic; the source holds data until accepted.
    acc = 0; cyc = 0; last_acc = 1'b0;
    while (acc < 1000 && cyc < 20000) begin
      @(posedge clk); #1;
      cyc++;
      if (last_acc) acc++;
      if (!in_valid || last_acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_code  = IN_W'($urandom_range(0, 7));
        in_mode  = 1'($urandom_range(0, 1));
      end
      out_ready = ($urandom_range(0, 2) != 0);
      last_acc  = in_valid && in_ready;
    end
    check("rand_accepts_done", acc >= 1000, 1);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("drain_queue_empty", q.size(), 0);
    check("drain_out_valid",   out_valid, 0);
`ifdef DECODER_PIPE_STATS_EN
    check("stat_cnt",     stat_cnt,     m_stat_cnt);
    check("stat_err_cnt", stat_err_cnt, m_stat_err);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
